// File: rtl/layer3_mac_sequencer_pkg.sv
// Shared definitions for the layer-3 MAC sequencer.
// Holds the datapath width constants and the sequencer state encoding.
package layer3_mac_sequencer_pkg;

   localparam int W_WIDTH    = 13;   // signed weight width
   localparam int A_WIDTH    = 71;   // signed activation / bias width
   localparam int ACC_WIDTH  = 71;   // product and accumulator width
   localparam int ADDR_WIDTH = 10;   // RAM address width
   localparam int TAP_WIDTH  = 10;   // tap-count width

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/layer3_mac_mul.sv
// Combinational signed multiplier for the layer-3 MAC.
// Ports:
//   din0 : signed weight, W_WIDTH bits
//   din1 : signed activation, A_WIDTH bits
//   dout : full signed product truncated to its low ACC_WIDTH bits
module layer3_mac_mul
   import layer3_mac_sequencer_pkg::*;
(
   input  logic signed [W_WIDTH-1:0]   din0,
   input  logic signed [A_WIDTH-1:0]   din1,
   output logic signed [ACC_WIDTH-1:0] dout
);

   logic signed [W_WIDTH+A_WIDTH-1:0] full_prod;

   // Both operands are signed, so they are sign-extended to the full
   // product width before multiplying; the upper bits are then dropped,
   // giving modulo-2^ACC_WIDTH arithmetic.
   assign full_prod = din0 * din1;
   assign dout      = full_prod[ACC_WIDTH-1:0];

endmodule

// File: rtl/layer3_mac_sequencer.sv
// Layer-3 dot-product sequencer (ap_ctrl_hs handshake).
// Reads num_taps weight/activation pairs from two single-port RAMs with a
// one-cycle read latency, multiplies each pair, and sums the products into
// an accumulator preloaded with the bias.
// Ports:
//   ap_clk, ap_rst                : clock, synchronous active-high reset
//   ap_start/ap_idle/ap_ready/ap_done : block-level handshake
//   num_taps, w_base, a_base, bias    : run parameters, latched at start
//   w_address0/w_ce0/w_q0             : weight RAM port
//   a_address0/a_ce0/a_q0             : activation RAM port
//   ap_return                         : signed result, valid with ap_done
module layer3_mac_sequencer
   import layer3_mac_sequencer_pkg::*;
(
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic                        ap_start,
   output logic                        ap_idle,
   output logic                        ap_ready,
   output logic                        ap_done,
   input  logic [TAP_WIDTH-1:0]        num_taps,
   input  logic [ADDR_WIDTH-1:0]       w_base,
   input  logic [ADDR_WIDTH-1:0]       a_base,
   input  logic signed [A_WIDTH-1:0]   bias,
   output logic [ADDR_WIDTH-1:0]       w_address0,
   output logic                        w_ce0,
   input  logic signed [W_WIDTH-1:0]   w_q0,
   output logic [ADDR_WIDTH-1:0]       a_address0,
   output logic                        a_ce0,
   input  logic signed [A_WIDTH-1:0]   a_q0,
   output logic signed [ACC_WIDTH-1:0] ap_return
);

   state_t                      state_reg, state_next;
   logic [TAP_WIDTH-1:0]        idx_reg, idx_next;
   logic [TAP_WIDTH-1:0]        n_reg, n_next;
   logic [ADDR_WIDTH-1:0]       wb_reg, wb_next;
   logic [ADDR_WIDTH-1:0]       ab_reg, ab_next;
   logic                        rd_vld_reg, rd_vld_next;
   logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
   logic signed [ACC_WIDTH-1:0] ret_reg, ret_next;
   logic signed [ACC_WIDTH-1:0] prod;

   layer3_mac_mul u_mul (
      .din0 (w_q0),
      .din1 (a_q0),
      .dout (prod)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_reg  <= S_IDLE;
         idx_reg    <= '0;
         n_reg      <= '0;
         wb_reg     <= '0;
         ab_reg     <= '0;
         rd_vld_reg <= 1'b0;
         acc_reg    <= '0;
         ret_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         n_reg      <= n_next;
         wb_reg     <= wb_next;
         ab_reg     <= ab_next;
         rd_vld_reg <= rd_vld_next;
         acc_reg    <= acc_next;
         ret_reg    <= ret_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      n_next      = n_reg;
      wb_next     = wb_reg;
      ab_next     = ab_reg;
      rd_vld_next = rd_vld_reg;
      ret_next    = ret_reg;
      // RAM data lands one cycle after each read, so rd_vld_reg marks the
      // cycles whose w_q0/a_q0 belong to this run, whatever the state.
      acc_next    = rd_vld_reg ? (acc_reg + prod) : acc_reg;

      ap_idle     = 1'b0;
      ap_done     = 1'b0;
      ap_ready    = 1'b0;
      w_ce0       = 1'b0;
      a_ce0       = 1'b0;
      w_address0  = '0;
      a_address0  = '0;

      case (state_reg)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               n_next   = num_taps;
               wb_next  = w_base;
               ab_next  = a_base;
               idx_next = '0;
               // Signed cast sign-extends the bias to the accumulator width.
               acc_next = ACC_WIDTH'(bias);
               state_next = (num_taps == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            w_ce0       = 1'b1;
            a_ce0       = 1'b1;
            w_address0  = wb_reg + ADDR_WIDTH'(idx_reg);
            a_address0  = ab_reg + ADDR_WIDTH'(idx_reg);
            idx_next    = idx_reg + TAP_WIDTH'(1);
            rd_vld_next = 1'b1;
            if (idx_reg == n_reg - TAP_WIDTH'(1))
               state_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Last read's data is accumulated this cycle.
            rd_vld_next = 1'b0;
            state_next  = S_DONE;
         end
         S_DONE: begin
            ap_done    = 1'b1;
            ap_ready   = 1'b1;
            ret_next   = acc_reg;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Live accumulator in DONE, held copy of the last result elsewhere.
   assign ap_return = (state_reg == S_DONE) ? acc_reg : ret_reg;

endmodule
